// File: rtl/alu_flag_stage.sv
// Retire stage behind the ALU: 2-entry skid FIFO, condition-code evaluation, architectural NZCV flags.
// Optional build macro FLAG_BYPASS_EN forwards a retiring carry to Ci in the same cycle.
module alu_flag_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic              in_s,
    input  logic [3:0]        in_cond,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic [3:0]        psr_flags,
    output logic              Ci
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [3:0]        flags;
        logic              s;
        logic [3:0]        cond;
        logic [RD_W-1:0]   rd;
    } entry_t;

    entry_t     mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic [3:0] psr_q, psr_d;

    entry_t head;
    logic   push, pop, pass, upd;
    logic   fn, fz, fc, fv;

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {fn, fz, fc, fv} = psr_q;

    always_comb begin
        pass = 1'b0;
        case (head.cond)
            4'h0: pass = fz;
            4'h1: pass = ~fz;
            4'h2: pass = fc;
            4'h3: pass = ~fc;
            4'h4: pass = fn;
            4'h5: pass = ~fn;
            4'h6: pass = fv;
            4'h7: pass = ~fv;
            4'h8: pass = fc & ~fz;
            4'h9: pass = ~fc | fz;
            4'hA: pass = (fn == fv);
            4'hB: pass = (fn != fv);
            4'hC: pass = ~fz & (fn == fv);
            4'hD: pass = fz | (fn != fv);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    // Outputs are zeroed when empty so stale entries never show on the bus.
    assign out_we     = out_valid & pass;
    assign out_result = out_valid ? head.result : '0;
    assign out_rd     = out_valid ? head.rd : '0;
    assign upd        = pop & head.s & pass;
    assign psr_flags  = psr_q;

`ifdef FLAG_BYPASS_EN
    assign Ci = upd ? head.flags[1] : psr_q[1];
`else
    assign Ci = psr_q[1];
`endif

    always_comb begin
        psr_d    = upd ? head.flags : psr_q;
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        // A same-cycle pop still retires (and may update flags) before the discard.
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            psr_q    <= 4'b0000;
        end else begin
            if (push) mem_q[wr_ptr_q] <= '{result: in_result, flags: in_flags, s: in_s,
                                           cond: in_cond, rd: in_rd};
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            psr_q    <= psr_d;
        end
    end
endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: scoreboard monitor plus condition-code table and corner-case sequences.
module tb_alu_flag_stage;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [31:0] in_result = '0, out_result;
    logic [3:0]  in_flags = '0, in_cond = '0, in_rd = '0, out_rd, psr_flags;
    logic        in_s = 1'b0, out_valid, out_ready = 1'b0, out_we, Ci;

    alu_flag_stage #(.DATA_W(32), .RD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_s(in_s), .in_cond(in_cond),
        .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .psr_flags(psr_flags), .Ci(Ci));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        s;
        logic [3:0]  cond;
        logic [3:0]  rd;
    } beat_t;

    typedef struct {
        logic [3:0] set_flags;
        logic [3:0] cond;
        logic       exp_we;
    } vec_t;

    int    nvec = 0, nerr = 0;
    beat_t q[$];
    logic [3:0] mpsr = 4'b0000;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic cpass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v;
        {n, z, cc, v} = f;
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cc;         4'h3: return !cc;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cc && !z;   4'h9: return !cc || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard monitor: inputs are stable mid-cycle, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        beat_t      e;
        logic [3:0] npsr;
        logic       exp_ci, p;
        int         sz;
        if (!rst_n) begin
            q.delete();
            mpsr = 4'b0000;
        end else begin
            sz     = q.size();
            npsr   = mpsr;
            exp_ci = mpsr[1];
            chk("in_ready", in_ready, sz != 2);
            chk("out_valid", out_valid, sz != 0);
            chk("psr_flags", psr_flags, mpsr);
            if (sz != 0) begin
                e = q[0];
                p = cpass(e.cond, mpsr);
                chk("out_result", out_result, e.result);
                chk("out_rd", out_rd, e.rd);
                chk("out_we", out_we, p);
                if (out_ready) begin
                    if (e.s && p) begin
                        npsr = e.flags;
`ifdef FLAG_BYPASS_EN
                        exp_ci = e.flags[1];
`endif
                    end
                    void'(q.pop_front());
                end
            end else begin
                chk("out_we_empty", out_we, 1'b0);
            end
            chk("Ci", Ci, exp_ci);
            if (flush) q.delete();
            else if (in_valid && sz != 2) q.push_back('{in_result, in_flags, in_s, in_cond, in_rd});
            mpsr = npsr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [3:0] f,
                         input logic s, input logic [3:0] c, input logic [3:0] rd);
        in_valid = v; in_result = r; in_flags = f; in_s = s; in_cond = c; in_rd = rd;
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{4'b0100, 4'h0, 1'b1};  tbl[1]  = '{4'b0100, 4'h1, 1'b0};
        tbl[2]  = '{4'b0010, 4'h2, 1'b1};  tbl[3]  = '{4'b0010, 4'h3, 1'b0};
        tbl[4]  = '{4'b1000, 4'h4, 1'b1};  tbl[5]  = '{4'b1000, 4'h5, 1'b0};
        tbl[6]  = '{4'b0001, 4'h6, 1'b1};  tbl[7]  = '{4'b0000, 4'h7, 1'b1};
        tbl[8]  = '{4'b0010, 4'h8, 1'b1};  tbl[9]  = '{4'b0010, 4'h9, 1'b0};
        tbl[10] = '{4'b1001, 4'hA, 1'b1};  tbl[11] = '{4'b1000, 4'hB, 1'b1};
        tbl[12] = '{4'b0110, 4'hC, 1'b0};  tbl[13] = '{4'b0000, 4'hD, 1'b0};
        tbl[14] = '{4'b0000, 4'hE, 1'b1};  tbl[15] = '{4'b1111, 4'hF, 1'b0};

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_we", out_we, 1'b0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_rd", out_rd, 4'h0);
        chk("rst_psr", psr_flags, 4'h0);
        chk("rst_Ci", Ci, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // First retire: 1-cycle latency.
        out_ready = 1'b1;
        drive(1, 32'h5, 4'b0000, 1, 4'hE, 4'd3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("lat_out_valid", out_valid, 1'b1);
        chk("lat_out_we", out_we, 1'b1);
        chk("lat_out_rd", out_rd, 4'd3);
        chk("lat_out_result", out_result, 32'h5);
        tick();
        chk("lat_psr", psr_flags, 4'b0000);

        // Condition-code table: set flags, then retire the tested code back to back.
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h100 + i, tbl[i].set_flags, 1, 4'hE, 4'd1);
            tick();
            drive(1, 32'h200 + i, 4'b1111, 0, tbl[i].cond, 4'd2);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("tbl_we_%0d", i), out_we, tbl[i].exp_we);
            tick();
        end

        // Failed condition with s=1 must not touch flags.
        drive(1, 32'h0, 4'b0100, 1, 4'hE, 4'd4);
        tick();
        drive(1, 32'h77, 4'b1111, 1, 4'h1, 4'd7);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("ne_we", out_we, 1'b0);
        tick();
        chk("ne_psr_hold", psr_flags, 4'b0100);

        // Backpressure: three beats against a stalled sink.
        out_ready = 1'b0;
        for (int i = 0, n = 0; i < 3 && n < 20; n++) begin
            logic rdy;
            drive(1, 32'hA0 + i, 4'(i), 0, 4'hE, 4'(8 + i));
            rdy = in_ready;
            if (n == 5) out_ready = 1'b1;
            if (i == 2 && n < 5) chk("bp_in_ready", in_ready, 1'b0);
            tick();
            if (rdy) i++;
            if (n == 19) chk("bp_timeout", 1'b1, 1'b0);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        chk("bp_drained", out_valid, 1'b0);

        // Flush from FULL: head retires, second entry vanishes.
        out_ready = 1'b0;
        drive(1, 32'hB0, 4'b0000, 0, 4'hE, 4'd5); tick();
        drive(1, 32'hB1, 4'b0000, 0, 4'hE, 4'd6); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_full", in_ready, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty", out_valid, 1'b0);
        tick();
        // Flush in ONE with a simultaneous push: the push is dropped.
        out_ready = 1'b0;
        drive(1, 32'hC0, 4'b0000, 0, 4'hE, 4'd9); tick();
        drive(1, 32'hC1, 4'b0000, 0, 4'hE, 4'd10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk("fl_push_drop", out_valid, 1'b0);
        tick();

        // Carry feedback timing.
        out_ready = 1'b1;
        drive(1, 32'h1, 4'b0010, 1, 4'hE, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
`ifdef FLAG_BYPASS_EN
        chk("ci_pop_cycle", Ci, 1'b1);
`else
        chk("ci_pop_cycle", Ci, 1'b0);
`endif
        tick();
        chk("ci_after", Ci, 1'b1);

        // Async reset while FULL.
        out_ready = 1'b0;
        drive(1, 32'hD0, 4'b0000, 0, 4'hE, 4'd1); tick();
        drive(1, 32'hD1, 4'b0000, 0, 4'hE, 4'd2); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("ar_full", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_Ci", Ci, 1'b0);
        chk("ar_psr", psr_flags, 4'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_in_ready", in_ready, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
Retire stage directly downstream of the 32-bit ALU. It buffers ALU results in a 2-entry skid FIFO and holds the architectural status flags (Z,N,C,V). At retire it evaluates each instruction's 4-bit condition code against those flags, then gates the register-file write and the flag update. It also feeds the registered carry back to the ALU's Ci input.

Parameters:
DATA_W, 32, width of ALU result and out_result
RD_W, 4, width of destination register index

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  ALU result beat valid
in_ready  output  1  stage can accept a beat
in_result  input  DATA_W  ALU OUT
in_flags  input  4  ALU {N,Z,C,V}
in_s  input  1  instruction requests flag update
in_cond  input  4  condition code
in_rd  input  RD_W  destination register
out_valid  output  1  head entry available for retire
out_ready  input  1  downstream accepts retire
out_result  output  DATA_W  head result
out_rd  output  RD_W  head destination
out_we  output  1  head condition passed (write enable)
psr_flags  output  4  architectural {N,Z,C,V}
Ci  output  1  carry to ALU, equals psr_flags[1]

Behaviour:
- Reset (async, rst_n=0): count=0, both entries invalid, psr_flags=4'b0000, Ci=0, out_valid=0, out_we=0, out_result=0, out_rd=0. A reset mid-stream drops buffered entries. in_ready=1 on release.
- FIFO states: EMPTY (count 0), ONE (count 1), FULL (count 2).
- Handshake signals: push = in_valid & in_ready; pop = out_valid & out_ready. in_ready = (count!=2), driven from registered count only, with no combinational path from out_ready. out_valid = (count!=0).
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push only -> FULL.
  - ONE + pop only -> EMPTY.
  - ONE + push & pop -> ONE; the new entry becomes head next cycle.
  - FULL + pop -> ONE. No push is possible in FULL.
- Ordering and latency: strict FIFO order. Latency is 1 cycle: a beat pushed at edge k is visible on out_* after edge k when the FIFO was EMPTY.
- Condition evaluation: combinational on the head entry against the current psr_flags.
  - Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - Codes: 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
  - out_we = out_valid & pass.
- Flag update: on pop, if head.s & pass, psr_flags <= head flags at that edge. Otherwise the flags hold. Failed-condition instructions still retire (out_valid=1, out_we=0) and never update flags.
- C is taken raw from the ALU, including the borrow convention for subtracts. No reinterpretation.
- Flush: count <= 0 at next edge. A beat pushed in the same cycle is discarded. A pop in the same cycle still completes, including its flag update. psr_flags is otherwise untouched.
- Simultaneous flush and reset: reset wins.

Optional Feature:
Macro FLAG_BYPASS_EN.
- Defined: Ci is combinational. During a flag-updating pop, Ci = head C flag in that same cycle; otherwise Ci = psr_flags[1]. The ALU therefore sees the new carry one cycle early.
- Undefined: Ci is purely registered (psr_flags[1]). Same-cycle consumers see the old carry.
- psr_flags itself is always registered in both builds.

Test Plan:
- Reset then push {result=0x0000_0005, flags=0000, s=1, cond=E, rd=3} with out_ready=1 -> next cycle out_valid=1, out_we=1, out_rd=3, out_result=5; after the pop, psr_flags=0000.
- Push subtract result 0 with flags Z=1,C=0 (0100), s=1, cond=E, then push cond=0 (EQ) rd=7 -> second retire has out_we=1. Repeat with cond=1 (NE) -> out_we=0, and psr_flags stays 0100.
- Hold out_ready=0 and push 3 beats -> in_ready drops to 0 after 2 accepts and the third beat is held. Release out_ready -> beats retire in order with no loss or duplicate.
- FULL, then assert flush with out_ready=1 -> head pops that cycle; count=0 next cycle and the remaining entry is never output.
- Set C=1 via s=1 with flags 0010 -> Ci=1 one cycle after the pop. With FLAG_BYPASS_EN defined, Ci=1 during the pop cycle.
- Assert rst_n=0 asynchronously while FULL -> out_valid, Ci and psr_flags clear immediately without a clock edge.
